// File: rtl/mode_controller.sv
// mode_controller: button-driven mode sequencer for the digital clock, with field blink,
// commit pulses and inactivity timeout for the time-set and alarm-set modes.
module mode_controller #(
    parameter int BLINK_DIV       = 50_000_000,
    parameter int TIMEOUT_TOGGLES = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_next,
    output logic [2:0] mode,
    output logic       enable_time_set,
    output logic       enable_alarm_set,
    output logic       enable_stopwatch,
    output logic       enable_game,
    output logic [3:0] blink_state,
    output logic       commit_time,
    output logic       commit_alarm
);
    localparam int CNT_W  = $clog2(BLINK_DIV);
    localparam int IDLE_W = $clog2(TIMEOUT_TOGGLES + 1);

    typedef enum logic [2:0] {
        CLOCK     = 3'd0,
        TIME_SET  = 3'd1,
        ALARM_SET = 3'd2,
        STOPWATCH = 3'd3,
        GAME      = 3'd4
    } mode_e;

    mode_e             mode_q, mode_d;
    logic              field_q, field_d;
    logic              phase_q, phase_d;
    logic [CNT_W-1:0]  blink_cnt_q, blink_cnt_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic              commit_time_q, commit_time_d;
    logic              commit_alarm_q, commit_alarm_d;
    logic              in_set;
    logic              wrap;

    assign in_set = (mode_q == TIME_SET) || (mode_q == ALARM_SET);
    assign wrap   = (blink_cnt_q == CNT_W'(BLINK_DIV - 1));

    always_comb begin
        mode_d         = mode_q;
        field_d        = field_q;
        phase_d        = phase_q;
        blink_cnt_d    = blink_cnt_q;
        idle_cnt_d     = idle_cnt_q;
        commit_time_d  = 1'b0;
        commit_alarm_d = 1'b0;

        if (btn_mode) begin
            // btn_mode outranks both btn_next and a coinciding timeout toggle
            case (mode_q)
                CLOCK:     mode_d = TIME_SET;
                TIME_SET:  mode_d = ALARM_SET;
                ALARM_SET: mode_d = STOPWATCH;
                STOPWATCH: mode_d = GAME;
                default:   mode_d = CLOCK;
            endcase
            commit_time_d  = (mode_q == TIME_SET);
            commit_alarm_d = (mode_q == ALARM_SET);
        end else if (in_set) begin
            if (btn_next) begin
                field_d     = ~field_q;
                phase_d     = 1'b0;
                blink_cnt_d = '0;
                idle_cnt_d  = '0;
            end else if (wrap) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
                if (idle_cnt_q == IDLE_W'(TIMEOUT_TOGGLES - 1)) begin
                    mode_d = CLOCK;
                end else begin
                    idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                end
            end else begin
                blink_cnt_d = blink_cnt_q + CNT_W'(1);
            end
        end else if (!(mode_q inside {CLOCK, STOPWATCH, GAME})) begin
            mode_d = CLOCK;
        end

        // Any mode change restarts the edit context so a new set mode starts visible on HOURS
        if (mode_d != mode_q) begin
            field_d     = 1'b0;
            phase_d     = 1'b0;
            blink_cnt_d = '0;
            idle_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q         <= CLOCK;
            field_q        <= 1'b0;
            phase_q        <= 1'b0;
            blink_cnt_q    <= '0;
            idle_cnt_q     <= '0;
            commit_time_q  <= 1'b0;
            commit_alarm_q <= 1'b0;
        end else begin
            mode_q         <= mode_d;
            field_q        <= field_d;
            phase_q        <= phase_d;
            blink_cnt_q    <= blink_cnt_d;
            idle_cnt_q     <= idle_cnt_d;
            commit_time_q  <= commit_time_d;
            commit_alarm_q <= commit_alarm_d;
        end
    end

    assign mode             = mode_q;
    assign enable_time_set  = (mode_q == TIME_SET);
    assign enable_alarm_set = (mode_q == ALARM_SET);
    assign enable_stopwatch = (mode_q == STOPWATCH);
    assign enable_game      = (mode_q == GAME);
    assign blink_state      = (in_set && phase_q) ? (field_q ? 4'b1100 : 4'b0011) : 4'b0000;
    assign commit_time      = commit_time_q;
    assign commit_alarm     = commit_alarm_q;
endmodule

// File: tb/tb_mode_controller.sv
// Testbench for mode_controller: directed scenarios plus random button traffic
// compared each cycle against a cycle-count reference model.
module tb_mode_controller;
    localparam int BD = 4;
    localparam int TO = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_next = 1'b0;
    logic [2:0] mode;
    logic       enable_time_set, enable_alarm_set, enable_stopwatch, enable_game;
    logic [3:0] blink_state;
    logic       commit_time, commit_alarm;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: mode number, field, cycles since last edit restart, commit flags
    int m_mode = 0;
    int m_field = 0;
    int m_t = 0;
    bit m_ct = 1'b0;
    bit m_ca = 1'b0;

    mode_controller #(.BLINK_DIV(BD), .TIMEOUT_TOGGLES(TO)) dut (
        .clk              (clk),
        .reset            (reset),
        .btn_mode         (btn_mode),
        .btn_next         (btn_next),
        .mode             (mode),
        .enable_time_set  (enable_time_set),
        .enable_alarm_set (enable_alarm_set),
        .enable_stopwatch (enable_stopwatch),
        .enable_game      (enable_game),
        .blink_state      (blink_state),
        .commit_time      (commit_time),
        .commit_alarm     (commit_alarm)
    );

    always #5 clk = ~clk;

    logic [12:0] obs;
    assign obs = {mode, enable_time_set, enable_alarm_set, enable_stopwatch, enable_game,
                  blink_state, commit_time, commit_alarm};

    function automatic logic [12:0] model_outs();
        logic [3:0] mask;
        logic [3:0] bl;
        bit         set_mode;
        set_mode = (m_mode == 1) || (m_mode == 2);
        mask = (m_field != 0) ? 4'b1100 : 4'b0011;
        bl = (set_mode && (((m_t / BD) % 2) == 1)) ? mask : 4'b0000;
        return {3'(m_mode), m_mode == 1, m_mode == 2, m_mode == 3, m_mode == 4, bl, m_ct, m_ca};
    endfunction

    // Drive buttons for one edge, advance the model at that edge, settle 1 time unit
    task automatic tick(input bit bm, input bit bn);
        btn_mode = bm;
        btn_next = bn;
        @(posedge clk);
        m_ct = 1'b0;
        m_ca = 1'b0;
        if (reset) begin
            m_mode = 0; m_field = 0; m_t = 0;
        end else if (bm) begin
            m_ct = (m_mode == 1);
            m_ca = (m_mode == 2);
            m_mode = (m_mode + 1) % 5;
            m_field = 0; m_t = 0;
        end else if (m_mode == 1 || m_mode == 2) begin
            if (bn) begin
                m_field ^= 1; m_t = 0;
            end else begin
                m_t++;
                if (m_t == TO * BD) begin
                    m_mode = 0; m_t = 0;
                end
            end
        end
        #1;
        btn_mode = 1'b0;
        btn_next = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b1);
            vectors++;
            if (obs !== 13'd0) begin
                $display("FAIL reset cyc=%0d got=%h exp=%h", i, obs, 13'd0);
                miscompares++;
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_mode_cycle();
        int exp_seq[5] = '{1, 2, 3, 4, 0};
        int ct_seen = 0;
        int ca_seen = 0;
        do_reset();
        for (int p = 0; p < 5; p++) begin
            for (int c = 0; c < 10; c++) begin
                tick(c == 0, 1'b0);
                ct_seen += int'(commit_time);
                ca_seen += int'(commit_alarm);
                vectors++;
                if (obs !== model_outs()) begin
                    $display("FAIL mode_cycle p=%0d c=%0d got=%h exp=%h", p, c, obs, model_outs());
                    miscompares++;
                end
            end
            vectors++;
            if (int'(mode) != exp_seq[p]) begin
                $display("FAIL mode_seq p=%0d got=%0d exp=%0d", p, mode, exp_seq[p]);
                miscompares++;
            end
        end
        vectors++;
        if (ct_seen != 1 || ca_seen != 1) begin
            $display("FAIL commit_count got ct=%0d ca=%0d exp ct=1 ca=1", ct_seen, ca_seen);
            miscompares++;
        end
    endtask

    task automatic test_blink();
        logic [3:0] exp_b;
        do_reset();
        tick(1'b1, 1'b0);
        for (int j = 0; j < 12; j++) begin
            if (j > 0) tick(1'b0, 1'b0);
            exp_b = (j >= 4 && j < 8) ? 4'b0011 : 4'b0000;
            vectors++;
            if (blink_state !== exp_b || obs !== model_outs()) begin
                $display("FAIL blink N+%0d got=%b exp=%b", j, blink_state, exp_b);
                miscompares++;
            end
        end
    endtask

    task automatic test_field_toggle();
        logic [3:0] exp_b;
        do_reset();
        tick(1'b1, 1'b0);
        for (int j = 0; j < 5; j++) tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        for (int j = 0; j < 8; j++) begin
            if (j > 0) tick(1'b0, 1'b0);
            exp_b = (j >= 4) ? 4'b1100 : 4'b0000;
            vectors++;
            if (blink_state !== exp_b || obs !== model_outs()) begin
                $display("FAIL field_toggle N+%0d got=%b exp=%b", j + 6, blink_state, exp_b);
                miscompares++;
            end
        end
    endtask

    task automatic test_timeout();
        bit ca_any = 1'b0;
        do_reset();
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        for (int i = 1; i <= 24; i++) begin
            tick(1'b0, 1'b0);
            ca_any |= commit_alarm;
            vectors++;
            if (enable_alarm_set !== (i < 24) || obs !== model_outs()) begin
                $display("FAIL timeout N+%0d got en=%b exp en=%b", i, enable_alarm_set, i < 24);
                miscompares++;
            end
        end
        vectors++;
        if (mode !== 3'd0 || ca_any !== 1'b0) begin
            $display("FAIL timeout_end got mode=%0d ca=%b exp mode=0 ca=0", mode, ca_any);
            miscompares++;
        end
    endtask

    task automatic test_timeout_race();
        do_reset();
        tick(1'b1, 1'b0);
        for (int i = 0; i < 23; i++) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        vectors++;
        if (mode !== 3'd2 || commit_time !== 1'b1) begin
            $display("FAIL timeout_race got mode=%0d ct=%b exp mode=2 ct=1", mode, commit_time);
            miscompares++;
        end
    endtask

    task automatic test_simultaneous();
        int ct_seen = 0;
        do_reset();
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b1);
        for (int j = 0; j < 6; j++) begin
            if (j > 0) tick(1'b0, 1'b0);
            ct_seen += int'(commit_time);
            vectors++;
            if (mode !== 3'd2 || obs !== model_outs()) begin
                $display("FAIL simultaneous j=%0d got=%h exp=%h", j, obs, model_outs());
                miscompares++;
            end
        end
        vectors++;
        if (blink_state !== 4'b0011 || ct_seen != 1) begin
            $display("FAIL simultaneous_end got blink=%b ct=%0d exp blink=0011 ct=1", blink_state, ct_seen);
            miscompares++;
        end
    endtask

    task automatic test_reset_mid_edit();
        do_reset();
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b1);
        for (int j = 0; j < 4; j++) tick(1'b0, 1'b0);
        vectors++;
        if (blink_state !== 4'b1100) begin
            $display("FAIL mid_edit_pre got=%b exp=1100", blink_state);
            miscompares++;
        end
        reset = 1'b1;
        tick(1'b0, 1'b0);
        reset = 1'b0;
        vectors++;
        if (obs !== 13'd0) begin
            $display("FAIL mid_edit_reset got=%h exp=%h", obs, 13'd0);
            miscompares++;
        end
        tick(1'b0, 1'b0);
        vectors++;
        if (obs !== 13'd0) begin
            $display("FAIL mid_edit_after got=%h exp=%h", obs, 13'd0);
            miscompares++;
        end
    endtask

    task automatic test_random();
        bit bm, bn;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bm = ($urandom_range(0, 39) == 0);
            bn = ($urandom_range(0, 29) == 0);
            reset = ($urandom_range(0, 299) == 0);
            tick(bm, bn);
            vectors++;
            if (obs !== model_outs()) begin
                $display("FAIL random cyc=%0d got=%h exp=%h", i, obs, model_outs());
                miscompares++;
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mode_cycle();
        test_blink();
        test_field_toggle();
        test_timeout();
        test_timeout_race();
        test_simultaneous();
        test_reset_mid_edit();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
